// File: rtl/rv32i_types.sv
// Shared types and constants for the cacheline arbiter.
//   arb_state_t    : arbiter FSM states
//   LINE_OFFSET_W  : byte-offset width within a 32-byte cache line
//   LINE_ADDR_MASK : clears the line-offset bits of a byte address
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        D_XFER  = 2'd1,
        I_XFER  = 2'd2,
        PF_XFER = 2'd3
    } arb_state_t;

    localparam int unsigned LINE_OFFSET_W = 5;

    localparam logic [31:0] LINE_ADDR_MASK = ~((32'd1 << LINE_OFFSET_W) - 32'd1);

endpackage

// File: rtl/cacheline_arbiter.sv
// Arbitrates D-cache, I-cache and prefetcher line requests onto a single
// cacheline adaptor port.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   i_read/i_address             I-cache line read request
//   i_rdata/i_resp               I-cache line data and completion pulse
//   d_read/d_write/d_address/d_wdata  D-cache line read/writeback request
//   d_rdata/d_resp               D-cache line data and completion pulse
//   pf_read/pf_address           prefetcher line read request
//   pf_rdata/pf_resp             prefetcher line data and completion pulse
//   mem_read/mem_write/mem_address/mem_wdata  request to the adaptor
//   mem_rdata/mem_resp           adaptor line data and completion
module cacheline_arbiter
    import rv32i_types::*;
#(
    parameter bit PF_ENABLE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         i_read,
    input  logic [31:0]  i_address,
    output logic [255:0] i_rdata,
    output logic         i_resp,

    input  logic         d_read,
    input  logic         d_write,
    input  logic [31:0]  d_address,
    input  logic [255:0] d_wdata,
    output logic [255:0] d_rdata,
    output logic         d_resp,

    input  logic         pf_read,
    input  logic [31:0]  pf_address,
    output logic [255:0] pf_rdata,
    output logic         pf_resp,

    output logic         mem_read,
    output logic         mem_write,
    output logic [31:0]  mem_address,
    output logic [255:0] mem_wdata,
    input  logic [255:0] mem_rdata,
    input  logic         mem_resp
);

    arb_state_t   r_state;
    arb_state_t   w_state_next;

    logic [31:0]  r_addr;
    logic [255:0] r_wdata;
    logic         r_write;

    logic [31:0]  w_grant_addr;
    logic [255:0] w_grant_wdata;
    logic         w_grant_write;
    logic         w_xfer;

    // Next-state and grant selection. Grants happen only from IDLE, so a
    // transfer in flight is never preempted.
    always_comb begin
        w_state_next  = r_state;
        w_grant_addr  = '0;
        w_grant_wdata = '0;
        w_grant_write = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (d_read || d_write) begin
                    w_state_next  = D_XFER;
                    w_grant_addr  = d_address;
                    // read+write together is a writeback
                    w_grant_write = d_write;
                    w_grant_wdata = d_write ? d_wdata : '0;
                end else if (i_read) begin
                    w_state_next = I_XFER;
                    w_grant_addr = i_address;
                end else if (pf_read && PF_ENABLE) begin
                    w_state_next = PF_XFER;
                    w_grant_addr = pf_address;
                end
            end
            D_XFER, I_XFER, PF_XFER: begin
                if (mem_resp) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && w_state_next != IDLE) begin
                r_addr  <= w_grant_addr & LINE_ADDR_MASK;
                r_wdata <= w_grant_wdata;
                r_write <= w_grant_write;
            end
        end
    end

    assign w_xfer      = (r_state != IDLE);
    assign mem_read    = w_xfer & ~r_write;
    assign mem_write   = w_xfer & r_write;
    assign mem_address = r_addr;
    assign mem_wdata   = r_wdata;

    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;
    assign pf_rdata = mem_rdata;

    assign d_resp  = (r_state == D_XFER)  & mem_resp;
    assign i_resp  = (r_state == I_XFER)  & mem_resp;
    assign pf_resp = (r_state == PF_XFER) & mem_resp;

endmodule

// File: doc/cacheline_arbiter.md
CACHELINE_ARBITER -- requirements
Module: cacheline_arbiter

Interface
REQ-001 Parameter PF_ENABLE, default 1; when 0 the prefetch port is never granted.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-004 i_read, i_address  in  1, 32  I-cache line read request and byte address.
REQ-005 i_rdata, i_resp  out  256, 1  I-cache line data and one-cycle completion pulse.
REQ-006 d_read, d_write, d_address, d_wdata  in  1, 1, 32, 256  D-cache line read/writeback request.
REQ-007 d_rdata, d_resp  out  256, 1  D-cache line data and one-cycle completion pulse.
REQ-008 pf_read, pf_address  in  1, 32  prefetcher line read request.
REQ-009 pf_rdata, pf_resp  out  256, 1  prefetcher line data and one-cycle completion pulse.
REQ-010 mem_read, mem_write, mem_address, mem_wdata  out  1, 1, 32, 256  request to cacheline adaptor.
REQ-011 mem_rdata, mem_resp  in  256, 1  adaptor line data and completion.

Function
REQ-012 FSM states SHALL be IDLE, D_XFER, I_XFER, PF_XFER.
REQ-013 In IDLE, fixed priority SHALL be D (d_read|d_write) > I (i_read) > PF (pf_read & PF_ENABLE); winner's state is entered next cycle.
REQ-014 At grant, address, wdata and read/write direction SHALL be latched; mem_* outputs driven only from latched values.
REQ-015 mem_address[4:0] SHALL be 5'b0 regardless of requester address low bits.
REQ-016 D-cache with both d_read and d_write asserted SHALL be treated as a write.
REQ-017 mem_read/mem_write SHALL be high every cycle in an XFER state until and including the mem_resp cycle.
REQ-018 *_rdata SHALL equal mem_rdata combinationally on all three ports.
REQ-019 Exactly the granted port's *_resp SHALL equal mem_resp while in its XFER state; all other *_resp 0.
REQ-020 On mem_resp in an XFER state, FSM SHALL return to IDLE next cycle; minimum one IDLE cycle between transfers (requester deasserts after its resp).
REQ-021 mem_resp in IDLE SHALL be ignored (no *_resp pulse, no state change).
REQ-022 Requests changing or dropping mid-transfer SHALL NOT affect the transfer in flight; no preemption, including of PF by D or I.
REQ-023 Simultaneous D, I, PF requests in IDLE SHALL serve D, then I, then PF, each separated by one IDLE cycle, given requests held.
REQ-024 Grant-to-mem_read latency: mem_read high first cycle after request seen in IDLE.

Reset
REQ-025 rst SHALL force IDLE and clear latched address/wdata/direction to 0.
REQ-026 Out of reset all mem_read, mem_write, i_resp, d_resp, pf_resp SHALL be 0; mem_address 0.
REQ-027 rst mid-transfer SHALL abandon it: next cycle IDLE, no *_resp for a mem_resp arriving after reset.

Structure
REQ-028 arb_state_t enum SHALL live in shared package rv32i_types; line-offset width constant (5) likewise.
REQ-029 Single module, no sub-modules; FSM next-state logic combinational, state and latches in one clocked process.

Verification
REQ-030 d_read at 0x1000, mem_resp after 4 cycles with rdata 0xAA..AA -> mem_read cycles 1-5, d_resp pulse once, d_rdata 0xAA..AA.
REQ-031 i_read 0x2004, pf_read 0x2024, d_write 0x3000 same cycle -> mem order write 0x3000, read 0x2000, read 0x2020; one IDLE cycle between.
REQ-032 PF granted at 0x4020, then d_read asserted -> PF completes with pf_resp only; D granted after IDLE.
REQ-033 PF_ENABLE=0, pf_read held 20 cycles -> mem_read never asserted.
REQ-034 rst in cycle 2 of I_XFER, mem_resp in cycle 3 -> i_resp stays 0, state IDLE, mem_read 0.
REQ-035 Stray mem_resp in IDLE -> no *_resp pulse, state unchanged.
